// File: rtl/cpu_pkg.sv
// Shared definitions for the simple 16-bit processor.
// Holds the opcode encodings, the instruction field bit positions and the
// state encoding of the instruction fetch/decode FSM.
package cpu_pkg;

    // Opcode encodings, instruction bits [15:12]
    localparam logic [3:0] OP_MOVR = 4'h2;  // MOV Rd,Rs
    localparam logic [3:0] OP_MOVI = 4'h3;  // MOV Rd,#imm
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_JZ   = 4'h6;
    localparam logic [3:0] OP_RL   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction field bit positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 4;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Fetch/decode FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LATCH  = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_BRANCH = 3'd4,
        ST_HALT   = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/ir_decode.sv
// Combinational instruction splitter.
// Ports:
//   ir        in   M  instruction word
//   op        out  4  opcode, ir[15:12]
//   rd        out  4  destination/test register, ir[11:8]
//   rs        out  4  source register, ir[7:4]
//   imm       out  8  immediate / jump target / address, ir[7:0]
//   is_legal  out  1  opcode is one of the defined instructions
//   is_jz     out  1  opcode is JZ
//   is_halt   out  1  opcode is HALT
module ir_decode
    import cpu_pkg::*;
#(
    parameter int M = 16
) (
    input  logic [M-1:0] ir,
    output logic [3:0]   op,
    output logic [3:0]   rd,
    output logic [3:0]   rs,
    output logic [7:0]   imm,
    output logic         is_legal,
    output logic         is_jz,
    output logic         is_halt
);

    assign op  = ir[OP_MSB:OP_LSB];
    assign rd  = ir[RD_MSB:RD_LSB];
    assign rs  = ir[RS_MSB:RS_LSB];
    assign imm = ir[IMM_MSB:IMM_LSB];

    // Opcode classification
    always_comb begin
        is_legal = 1'b0;
        is_jz    = 1'b0;
        is_halt  = 1'b0;
        case (ir[OP_MSB:OP_LSB])
            OP_MOVR, OP_MOVI, OP_ADD, OP_SUB, OP_RL, OP_ST: begin
                is_legal = 1'b1;
            end
            OP_JZ: begin
                is_legal = 1'b1;
                is_jz    = 1'b1;
            end
            OP_HALT: begin
                is_legal = 1'b1;
                is_halt  = 1'b1;
            end
            default: begin
                is_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/decode unit.
// Reads the program ROM, holds the PC, decodes each word and hands it to the
// execute stage over a valid/ready handshake. JZ waits in BRANCH for the
// branch outcome from execute; HALT or an illegal opcode parks the unit in
// HALT until the next start pulse.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin execution at address 0 (from IDLE or HALT)
//   rom_rd, rom_addr    ROM read strobe and address (only in FETCH)
//   rom_data            ROM word, valid the cycle after rom_rd
//   dec_valid/ready     decoded instruction handshake
//   dec_op/rd/rs/imm    instruction fields, dec_pc its fetch address
//   br_valid, br_taken  JZ outcome reported by execute in BRANCH
//   halted, illegal     stopped; illegal is sticky until start
// All outputs are registers loaded from the next-state values, so they
// change on the same edge as the FSM state they describe.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         rom_rd,
    output logic [N-1:0] rom_addr,
    input  logic [M-1:0] rom_data,
    output logic         dec_valid,
    input  logic         dec_ready,
    output logic [3:0]   dec_op,
    output logic [3:0]   dec_rd,
    output logic [3:0]   dec_rs,
    output logic [7:0]   dec_imm,
    output logic [N-1:0] dec_pc,
    input  logic         br_valid,
    input  logic         br_taken,
    output logic         halted,
    output logic         illegal
);

    localparam logic [N-1:0] PC_ONE = {{(N-1){1'b0}}, 1'b1};

    fetch_state_t state_r, state_nxt_s;
    logic [N-1:0] pc_r, pc_nxt_s;
    logic [M-1:0] ir_r, ir_nxt_s;
    logic [N-1:0] ir_pc_r, ir_pc_nxt_s;
    logic         illegal_r, illegal_nxt_s;

    logic [M-1:0] dec_in_s;
    logic [3:0]   op_s, rd_s, rs_s;
    logic [7:0]   imm_s;
    logic         is_legal_s, is_jz_s, is_halt_s;

    logic         rom_rd_r;
    logic [N-1:0] rom_addr_r;
    logic         dec_valid_r;
    logic [3:0]   dec_op_r, dec_rd_r, dec_rs_r;
    logic [7:0]   dec_imm_r;
    logic [N-1:0] dec_pc_r;
    logic         halted_r;

    // In LATCH the decoder looks at the incoming ROM word (it is the next ir
    // and must be classified before it is stored); otherwise at the held ir.
    assign dec_in_s = (state_r == ST_LATCH) ? rom_data : ir_r;

    ir_decode #(.M(M)) u_dec (
        .ir       (dec_in_s),
        .op       (op_s),
        .rd       (rd_s),
        .rs       (rs_s),
        .imm      (imm_s),
        .is_legal (is_legal_s),
        .is_jz    (is_jz_s),
        .is_halt  (is_halt_s)
    );

    // Next-state, PC, IR and sticky illegal flag
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        ir_nxt_s      = ir_r;
        ir_pc_nxt_s   = ir_pc_r;
        illegal_nxt_s = illegal_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_FETCH;
                    pc_nxt_s    = {N{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_nxt_s = ST_LATCH;
            end
            ST_LATCH: begin
                ir_nxt_s    = rom_data;
                ir_pc_nxt_s = pc_r;
                pc_nxt_s    = pc_r + PC_ONE;
                if (is_halt_s) begin
                    state_nxt_s = ST_HALT;
                end else if (!is_legal_s) begin
                    state_nxt_s   = ST_HALT;
                    illegal_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (dec_ready) begin
                    if (is_jz_s) begin
                        state_nxt_s = ST_BRANCH;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_BRANCH: begin
                if (br_valid) begin
                    state_nxt_s = ST_FETCH;
                    if (br_taken) begin
                        pc_nxt_s = N'(imm_s);
                    end else begin
                        pc_nxt_s = pc_r;
                    end
                end else begin
                    state_nxt_s = ST_BRANCH;
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_nxt_s   = ST_FETCH;
                    pc_nxt_s      = {N{1'b0}};
                    illegal_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            pc_r      <= {N{1'b0}};
            ir_r      <= {M{1'b0}};
            ir_pc_r   <= {N{1'b0}};
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            ir_r      <= ir_nxt_s;
            ir_pc_r   <= ir_pc_nxt_s;
            illegal_r <= illegal_nxt_s;
        end
    end

    // Output registers; everything is zero outside the state that owns it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_rd_r    <= 1'b0;
            rom_addr_r  <= {N{1'b0}};
            dec_valid_r <= 1'b0;
            dec_op_r    <= 4'h0;
            dec_rd_r    <= 4'h0;
            dec_rs_r    <= 4'h0;
            dec_imm_r   <= 8'h00;
            dec_pc_r    <= {N{1'b0}};
            halted_r    <= 1'b0;
        end else begin
            rom_rd_r    <= (state_nxt_s == ST_FETCH);
            rom_addr_r  <= (state_nxt_s == ST_FETCH) ? pc_nxt_s : {N{1'b0}};
            dec_valid_r <= (state_nxt_s == ST_ISSUE);
            dec_op_r    <= (state_nxt_s == ST_ISSUE) ? op_s  : 4'h0;
            dec_rd_r    <= (state_nxt_s == ST_ISSUE) ? rd_s  : 4'h0;
            dec_rs_r    <= (state_nxt_s == ST_ISSUE) ? rs_s  : 4'h0;
            dec_imm_r   <= (state_nxt_s == ST_ISSUE) ? imm_s : 8'h00;
            dec_pc_r    <= (state_nxt_s == ST_ISSUE) ? ir_pc_nxt_s : {N{1'b0}};
            halted_r    <= (state_nxt_s == ST_HALT);
        end
    end

    assign rom_rd    = rom_rd_r;
    assign rom_addr  = rom_addr_r;
    assign dec_valid = dec_valid_r;
    assign dec_op    = dec_op_r;
    assign dec_rd    = dec_rd_r;
    assign dec_rs    = dec_rs_r;
    assign dec_imm   = dec_imm_r;
    assign dec_pc    = dec_pc_r;
    assign halted    = halted_r;
    assign illegal   = illegal_r;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch/decode unit for the simple 16-bit processor: reads the program ROM through its `rd`/address/data port, holds the program counter, splits each word into opcode/register/immediate fields and presents them to the execute stage over a valid/ready handshake. Sits between the program ROM and the execute/register-file stage. Resolves `JZ` control flow using a branch result returned by execute, and stops cleanly on `HALT` or an illegal opcode.

## Interface
- `N`, 8: ROM address width; PC width.
- `M`, 16: instruction width. Layout is fixed: op[15:12], rd[11:8], imm[7:0].
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse; begins execution at address 0 from IDLE or HALT.
- `rom_rd`  out  1  ROM read enable.
- `rom_addr`  out  N  ROM address (= PC while `rom_rd`).
- `rom_data`  in  M  ROM word; valid the cycle after `rom_rd`.
- `dec_valid`  out  1  decoded instruction available.
- `dec_ready`  in  1  execute accepts the instruction.
- `dec_op`  out  4  opcode.
- `dec_rd`  out  4  destination/test register, ir[11:8].
- `dec_rs`  out  4  source register, ir[7:4].
- `dec_imm`  out  8  immediate / jump target / memory address, ir[7:0].
- `dec_pc`  out  N  address the instruction was fetched from.
- `br_valid`  in  1  execute reports the JZ outcome.
- `br_taken`  in  1  JZ condition true (register was zero).
- `halted`  out  1  HALT reached or illegal opcode.
- `illegal`  out  1  sticky; the halt was caused by an illegal opcode.

## Operation
- Legal opcodes: 0010 MOV Rd,Rs; 0011 MOV Rd,#imm; 0100 ADD; 0101 SUB; 0110 JZ; 0111 RL; 1000 store; 1111 HALT. All others are illegal.
- FSM states: IDLE, FETCH, LATCH, ISSUE, BRANCH, HALT.
- IDLE: all outputs 0. `start` goes to FETCH with pc=0.
- FETCH: `rom_rd`=1, `rom_addr`=pc. Always goes to LATCH.
- LATCH: ir<=rom_data, ir_pc<=pc, pc<=pc+1 (mod 2^N, 255 wraps to 0).
  - HALT opcode: go to HALT.
  - Illegal opcode: go to HALT and set `illegal`.
  - Otherwise: go to ISSUE.
- ISSUE: `dec_valid`=1 and the fields are driven from ir. Fields hold stable until `dec_ready`.
  - On the handshake with op=JZ: go to BRANCH.
  - On the handshake with any other op: go to FETCH.
- BRANCH: `br_valid` sets pc<=br_taken ? ir[7:0] : pc, then goes to FETCH. `br_valid` in any other state is ignored.
- HALT: `halted`=1. `start` clears `halted` and `illegal`, sets pc=0 and goes to FETCH. HALT instructions are never issued.
- `start` outside IDLE/HALT is ignored.

## Timing
- Reset values: state IDLE, pc 0, ir 0; all outputs 0.
- Async `rst` mid-operation aborts any pending fetch, handshake or branch wait and returns to IDLE on the same edge.
- Non-pipelined; at most one instruction in flight.
- `start` at edge t: FETCH in cycle t+1, `dec_valid` high in cycle t+3.
- Sustained throughput with `dec_ready` tied 1: one instruction per 3 cycles.
- JZ adds the BRANCH cycles (at least 1) before the next FETCH.
- `dec_valid` drops the cycle after the handshake.
- `br_valid` in the same cycle as the JZ handshake is ignored; execute must report in BRANCH.
- `rom_rd` is high only in FETCH.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams: OP_MOVR, OP_MOVI, OP_ADD, OP_SUB, OP_JZ, OP_RL, OP_ST, OP_HALT;
  - field bit positions;
  - the fetch state enum.
- Sub-module `ir_decode` (combinational): splits ir into op/rd/rs/imm and outputs `is_legal`, `is_jz`, `is_halt`. It is reused by the disassembler/monitor.

## Test plan
- Reset, `start`, ROM word 0x3000 at address 0 → `rom_rd` with address 0 in cycle 1; `dec_valid` in cycle 3 with op=3, rd=0, imm=0x00, dec_pc=0.
- `dec_ready` held 0 for 5 cycles in ISSUE → `dec_valid` and fields stable, no ROM read; ready=1 → fetch of address 1 on the next cycle.
- JZ 0x6108 at address 4:
  - `br_valid`=1, `br_taken`=1 → next fetch address 8;
  - `br_taken`=0 → next fetch address 5;
  - `br_valid` asserted during ISSUE → ignored.
- 0xF00B at address 11 → `halted`=1, `dec_valid` never asserted for it; `start` → `halted`=0, fetch address 0.
- Opcode 0x9 at any address → `halted`=1, `illegal`=1, not issued; `start` clears both.
- Program running at address 255 (non-jump) → next fetch at address 0. `rst` asserted during BRANCH → outputs 0, IDLE, and no fetch until `start`.
